mem_arbiter: RTL and testbench

Single-port arbiter and sequencer for the shared toy RAM. Accepts instruction-fetch and data (load/store) requests from the pipeline, grants one at a time with data priority, and drives the RAM's `addr` / `mem_write` / `mem_stage_state` port. It also returns read data through a done-pulse handshake, and performs read-modify-write for sub-word stores. Sits between the IF/MEM stages and the RAM.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_store_merge.sv | 23 ++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: RAM port states, access sizes, FSM states.
package mem_arbiter_pkg;

    // RAM mem_stage_state encodings
    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] READ     = 2'b01;
    localparam logic [1:0] WRITE    = 2'b10;

    // Data access size codes (2'b11 behaves as a word)
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Arbiter FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_RESP  = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;

    function automatic logic is_subword(input logic [1:0] size);
        return (size == SIZE_B) || (size == SIZE_H);
    endfunction

endpackage

// File: rtl/mem_arbiter_store_merge.sv
// Combinational byte/half merge for read-modify-write stores.
module store_merge
    import mem_arbiter_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic [LEN-1:0] old_word,
    input  logic [LEN-1:0] new_data,
    input  logic [1:0]     size,
    output logic [LEN-1:0] merged
);

    // Replace only the low byte or half; anything else is a full-word replace
    always_comb begin
        merged = new_data;
        case (size)
            SIZE_B:  merged = {old_word[LEN-1:8], new_data[7:0]};
            SIZE_H:  merged = {old_word[LEN-1:16], new_data[15:0]};
            default: merged = new_data;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port arbiter/sequencer for the shared RAM. Data requests beat fetches.
// Build option: MEM_ARB_SUBWORD_STORE_EN enables read-modify-write for byte/half
// stores; without it every store writes the full word from mem_wdata.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [LEN-1:0]        if_inst,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [LEN-1:0]        mem_wdata,
    output logic                  mem_done,
    output logic [LEN-1:0]        mem_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [LEN-1:0]        ram_wdata,
    output logic [1:0]            ram_state,
    input  logic [LEN-1:0]        ram_rdata
);

    logic [2:0]            state_q, state_d;
    logic                  is_if_q, is_if_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN-1:0]        wdata_q, wdata_d;

`ifdef MEM_ARB_SUBWORD_STORE_EN
    logic       we_q, we_d;
    logic [1:0] size_q, size_d;
    logic [LEN-1:0] merged;

    store_merge #(
        .LEN(LEN)
    ) u_store_merge (
        .old_word(ram_rdata),
        .new_data(wdata_q),
        .size    (size_q),
        .merged  (merged)
    );
`else
    logic unused_size;
    assign unused_size = ^mem_size;
`endif

    // Next-state: grant in IDLE, then sequence the RAM access
    always_comb begin
        state_d = state_q;
        is_if_d = is_if_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef MEM_ARB_SUBWORD_STORE_EN
        we_d    = we_q;
        size_d  = size_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    is_if_d = 1'b0;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
`ifdef MEM_ARB_SUBWORD_STORE_EN
                    we_d    = mem_we;
                    size_d  = mem_size;
                    state_d = (mem_we && !is_subword(mem_size)) ? ST_WR : ST_RD;
`else
                    state_d = mem_we ? ST_WR : ST_RD;
`endif
                end else if (if_req) begin
                    // mem_we/mem_size belong to the data port and play no part here
                    is_if_d = 1'b1;
                    addr_d  = if_addr;
                    state_d = ST_RD;
`ifdef MEM_ARB_SUBWORD_STORE_EN
                    we_d    = 1'b0;
`endif
                end
            end
`ifdef MEM_ARB_SUBWORD_STORE_EN
            // Only sub-word stores reach RD with we set
            ST_RD:    state_d = we_q ? ST_MERGE : ST_RESP;
            ST_MERGE: begin
                wdata_d = merged;
                state_d = ST_WR;
            end
`else
            ST_RD:    state_d = ST_RESP;
`endif
            ST_RESP:  state_d = ST_IDLE;
            ST_WR:    state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and grant registers; async reset drops any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            is_if_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_ARB_SUBWORD_STORE_EN
            we_q    <= 1'b0;
            size_q  <= SIZE_W;
`endif
        end else begin
            state_q <= state_d;
            is_if_q <= is_if_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MEM_ARB_SUBWORD_STORE_EN
            we_q    <= we_d;
            size_q  <= size_d;
`endif
        end
    end

    // Outputs decoded from registered state so reset clears them without a clock
    always_comb begin
        ram_state = MEM_IDLE;
        if (state_q == ST_RD) ram_state = READ;
        if (state_q == ST_WR) ram_state = WRITE;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        if_done   = (state_q == ST_RESP) && is_if_q;
        mem_done  = ((state_q == ST_RESP) && !is_if_q) || (state_q == ST_WR);
        if_inst   = if_done ? ram_rdata : '0;
        mem_rdata = ((state_q == ST_RESP) && !is_if_q) ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed RAM model (wraps at 2^17).
module tb_mem_arbiter;

    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_RD   = 2'b01;
    localparam logic [1:0] M_WR   = 2'b10;

`ifdef MEM_ARB_SUBWORD_STORE_EN
    localparam int         SUB_LAT = 3;
    localparam logic [1:0] SUB_ST1 = M_RD;
    localparam logic [31:0] EXP_B  = 32'h112233AB;
    localparam logic [31:0] EXP_H  = 32'hCAFE33AB;
`else
    localparam int         SUB_LAT = 1;
    localparam logic [1:0] SUB_ST1 = M_WR;
    localparam logic [31:0] EXP_B  = 32'h000000AB;
    localparam logic [31:0] EXP_H  = 32'hCAFE00AB;
`endif

    logic        clk, rst;
    logic        if_req, if_done, mem_req, mem_we, mem_done;
    logic [16:0] if_addr, mem_addr, ram_addr;
    logic [1:0]  mem_size, ram_state;
    logic [31:0] if_inst, mem_wdata, mem_rdata, ram_wdata, ram_rdata;

    logic [7:0] mem [0:(1<<17)-1];

    int total = 0;
    int passed = 0;

    mem_arbiter #(
        .ADDR_WIDTH(17),
        .LEN       (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_inst  (if_inst),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_size (mem_size),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_done (mem_done),
        .mem_rdata(mem_rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_state(ram_state),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: little-endian, read data registered, address wraps
    always @(posedge clk) begin
        if (ram_state == M_RD) begin
            for (int i = 0; i < 4; i++)
                ram_rdata[8*i +: 8] <= mem[ram_addr + 17'(i)];
        end else if (ram_state == M_WR) begin
            for (int i = 0; i < 4; i++)
                mem[ram_addr + 17'(i)] <= ram_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic put_word(input logic [16:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 17'(i)] = w[8*i +: 8];
    endtask

    // Issue one request at the start of cycle 0; report done cycle, data, cycle-1 ram_state
    task automatic run_req(input logic f, input logic we, input logic [1:0] sz,
                           input logic [16:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] d, output logic [1:0] st1);
        lat = -1;
        d   = 'x;
        st1 = 'x;
        if (f) begin
            if_req = 1'b1; if_addr = a;
            mem_we = we; mem_size = sz;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 1) st1 = ram_state;
            if (f ? if_done : mem_done) begin
                lat = c;
                d   = f ? if_inst : mem_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    endtask

    typedef struct {
        logic        fetch;
        logic        we;
        logic [1:0]  size;
        logic [16:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [1:0]  st1;
        logic        chk_data;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int          lat, md, id;
        logic [31:0] d, mdat, idat;
        logic [1:0]  st1;

        vecs[0]  = '{1'b1, 1'b0, 2'b10, 17'h00010, 32'h0,        2,       M_RD,    1'b1, 32'h00000513};
        vecs[1]  = '{1'b0, 1'b1, 2'b10, 17'h00200, 32'hDEADBEEF, 1,       M_WR,    1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 2'b10, 17'h00200, 32'h0,        2,       M_RD,    1'b1, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 2'b00, 17'h00200, 32'h0,        2,       M_RD,    1'b1, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b0, 2'b10, 17'h00201, 32'h0,        2,       M_RD,    1'b1, 32'h00DEADBE};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 17'h00300, 32'h000000AB, SUB_LAT, SUB_ST1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 2'b10, 17'h00300, 32'h0,        2,       M_RD,    1'b1, EXP_B};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 17'h00302, 32'h1234CAFE, SUB_LAT, SUB_ST1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 17'h00300, 32'h0,        2,       M_RD,    1'b1, EXP_H};
        vecs[9]  = '{1'b0, 1'b1, 2'b11, 17'h1FFFE, 32'h55667788, 1,       M_WR,    1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 17'h00000, 32'h0,        2,       M_RD,    1'b1, 32'h00105566};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 17'h1FFFF, 32'h0,        2,       M_RD,    1'b1, 32'h10556677};

        for (int i = 0; i < (1 << 17); i++) mem[i] = 8'h00;
        put_word(17'h00000, 32'h00100093);
        put_word(17'h00010, 32'h00000513);
        put_word(17'h00100, 32'h0BADF00D);
        put_word(17'h00300, 32'h11223344);
        put_word(17'h00400, 32'h11111111);

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b10; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ram_state", {30'd0, ram_state}, 32'd0);
        chk("reset addr/dones", {13'd0, ram_addr, if_done, mem_done}, 32'd0);
        chk("reset ram_wdata", ram_wdata, 32'd0);
        chk("reset read data", if_inst | mem_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Simultaneous requests: data first, fetch follows with no bubble
        if_req = 1'b1; if_addr = 17'h0;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 17'h100;
        md = -1; id = -1; mdat = 'x; idat = 'x;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_done && md < 0) begin md = c; mdat = mem_rdata; end
            if (if_done && id < 0) begin id = c; idat = if_inst; end
            @(posedge clk); #1;
            if (md == c) mem_req = 1'b0;
            if (id == c) begin if_req = 1'b0; break; end
        end
        if_req = 1'b0; mem_req = 1'b0;
        chk("tie mem_done cycle", 32'(md), 32'd2);
        chk("tie mem_rdata", mdat, 32'h0BADF00D);
        chk("tie if_done cycle", 32'(id), 32'd5);
        chk("tie if_inst", idat, 32'h00100093);

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].fetch, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                    lat, d, st1);
            chk($sformatf("vec%0d done cycle", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d cycle1 ram_state", i), {30'd0, st1}, {30'd0, vecs[i].st1});
            if (vecs[i].chk_data) chk($sformatf("vec%0d data", i), d, vecs[i].data);
        end

        // Reset in the WR cycle of a word store must suppress the write
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 17'h400;
        mem_wdata = 32'hCAFEBABE;
        @(posedge clk); #1;
        chk("pre-reset WR state", {30'd0, ram_state}, {30'd0, M_WR});
        #1 rst = 1'b1;
        #1;
        chk("async reset ram_state", {30'd0, ram_state}, 32'd0);
        chk("async reset addr/dones", {13'd0, ram_addr, if_done, mem_done}, 32'd0);
        chk("async reset wdata/data", ram_wdata | if_inst | mem_rdata, 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_req(1'b0, 1'b0, 2'b10, 17'h400, 32'h0, lat, d, st1);
        chk("post-reset load cycle", 32'(lat), 32'd2);
        chk("post-reset load data", d, 32'h11111111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
